// File: rtl/udma_uart_rx_v2_pkg.sv
// Shared types and constants for the uDMA UART receiver.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package udma_uart_rx_v2_pkg;

    localparam int MIN_BITS = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    typedef struct packed {
        logic parity;
        logic frame;
        logic overrun;
    } err_t;

    // Out-of-range character lengths snap to the nearest supported length.
    function automatic logic [3:0] clamp_bits(input logic [3:0] bits, input int unsigned max_bits);
        if (bits < 4'(MIN_BITS)) begin
            return 4'(MIN_BITS);
        end
        if (32'(bits) > max_bits) begin
            return 4'(max_bits);
        end
        return bits;
    endfunction

endpackage

// File: rtl/udma_uart_rx_v2_if.sv
// RX channel from the receiver FIFO towards the uDMA: head data, valid/ready, occupancy.
// Latency: n/a (wiring only).
// Backpressure: rx_ready low holds the head entry; the producer side absorbs it in its FIFO.
interface udma_uart_rx_v2_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [CW-1:0]     fifo_count;

    modport master (output rx_data, output rx_valid, output fifo_count, input rx_ready);
    modport slave  (input rx_data, input rx_valid, input fifo_count, output rx_ready);

endinterface

// File: rtl/udma_uart_rx_fifo.sv
// Synchronous FIFO holding received characters; head is registered (no fall-through).
// Latency: a pushed entry is visible at the head one cycle after the push into an empty FIFO.
// Backpressure: push while full is ignored unless a pop happens in the same cycle; head is zero when empty.
module udma_uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               push_i,
    input  logic [DATA_W-1:0]                  push_dat_i,
    input  logic                               pop_i,
    output logic [DATA_W-1:0]                  pop_dat_o,
    output logic                               full_o,
    output logic                               empty_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_q;
    logic [AW-1:0]     rd_q;
    logic [CW-1:0]     cnt_q;
    logic              do_push;
    logic              do_pop;

    assign full_o    = (cnt_q == CW'(FIFO_DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign do_pop    = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push   = push_i & (~full_o | do_pop);
    assign pop_dat_o = empty_o ? '0 : mem_q[rd_q];
    assign count_o   = cnt_q;

    // Storage array: written at the write pointer, no reset needed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= push_dat_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/udma_uart_rx_v2.sv
// UART receiver (5..DATA_W data bits, none/even/odd parity, 1/2 stop bits) feeding an RX FIFO.
// Latency: char pushed one cycle after the middle of its last stop bit; rx_valid one cycle after the push.
// Backpressure: rx_ready low lets the FIFO fill; a char arriving while full is dropped and flags overrun.
// Build option: define UART_RX_MAJORITY_VOTE_EN for 3-sample majority voting per bit (cfg_div_i >= 4).
module udma_uart_rx_v2
    import udma_uart_rx_v2_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rx_i,
    input  logic             cfg_en_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic [3:0]       cfg_bits_i,
    input  logic             cfg_parity_en_i,
    input  logic             cfg_parity_odd_i,
    input  logic             cfg_stop_bits_i,
    output logic             busy_o,
    output logic             err_parity_o,
    output logic             err_frame_o,
    output logic             err_overrun_o,
    input  logic             err_clr_i,
    udma_uart_rx_v2_if.master rx_if
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_e            state_q, state_d;
    logic              sync1_q, sync2_q, prev_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
    logic              smp2_q;
`endif
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  mid1;
    logic [DIV_W-1:0]  decide_at;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        eff_bits;
    logic              stop_cnt_q, stop_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_q, par_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              fall, decide, bit_v, push;
    err_t              err_q, err_set;
    logic              fifo_full, fifo_empty, pop;
    logic [DATA_W-1:0] fifo_dat;
    logic [CW-1:0]     fifo_cnt;

    assign fall     = prev_q & ~sync2_q;
    assign eff_bits = clamp_bits(cfg_bits_i, DATA_W);
    assign mid1     = (cfg_div_i >> 1) + DIV_W'(1);
    assign decide   = (cnt_q == decide_at);

    // prev_q doubles as the mid-bit sample: decisions are taken one cycle after mid-bit.
`ifdef UART_RX_MAJORITY_VOTE_EN
    assign bit_v = (smp2_q & prev_q) | (smp2_q & sync2_q) | (prev_q & sync2_q);
`else
    assign bit_v = prev_q;
`endif

    // Synchroniser and sample delay line; parked at idle-high while disabled.
    always_ff @(posedge clk_i) begin
        if (rst_i || !cfg_en_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
`ifdef UART_RX_MAJORITY_VOTE_EN
            smp2_q  <= 1'b1;
`endif
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
            smp2_q  <= prev_q;
`endif
        end
    end

    // Decision cycle: mid+1 of the start bit, then one full bit period after each decision.
    always_comb begin
        decide_at = cfg_div_i;
        if (state_q == ST_START && mid1 <= cfg_div_i) begin
            decide_at = mid1;
        end
    end

    // FSM next state, bit assembly and push request.
    always_comb begin
        state_d    = state_q;
        cnt_d      = decide ? '0 : cnt_q + DIV_W'(1);
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        data_d     = data_q;
        par_d      = par_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d    = ST_START;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    data_d     = '0;
                    par_d      = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            ST_START: begin
                // A start bit that is high at mid-bit was a glitch: drop it silently.
                if (decide) begin
                    state_d = bit_v ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (decide) begin
                    data_d    = data_q | (DATA_W'(bit_v) << bit_cnt_q);
                    par_d     = par_q ^ bit_v;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q + 4'd1 == eff_bits) begin
                        state_d = cfg_parity_en_i ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (decide) begin
                    perr_d  = ((par_q ^ bit_v) != cfg_parity_odd_i);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    ferr_d = ferr_q | ~bit_v;
                    if (cfg_stop_bits_i && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Disabling aborts any frame in flight without pushing it.
        if (!cfg_en_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            push    = 1'b0;
        end
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            data_q     <= data_d;
            par_q      <= par_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign pop     = ~fifo_empty & rx_if.rx_ready;
    assign err_set = '{parity:  push & perr_q,
                       frame:   push & ferr_d,
                       overrun: push & fifo_full & ~pop};

    // Sticky error flags; clear wins over a simultaneous set.
    always_ff @(posedge clk_i) begin
        if (rst_i || err_clr_i) begin
            err_q <= '0;
        end else begin
            err_q <= err_q | err_set;
        end
    end

    udma_uart_rx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push),
        .push_dat_i (data_q),
        .pop_i      (pop),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt)
    );

    assign rx_if.rx_data    = fifo_dat;
    assign rx_if.rx_valid   = ~fifo_empty;
    assign rx_if.fifo_count = fifo_cnt;
    assign busy_o           = (state_q != ST_IDLE);
    assign err_parity_o     = err_q.parity;
    assign err_frame_o      = err_q.frame;
    assign err_overrun_o    = err_q.overrun;

endmodule
